// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with one outstanding line miss
module icache #(
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  valid_from_fetcher,
    input  logic [ADDR_WIDTH-1:0] pc_from_fetcher,
    input  logic                  flush,
    output logic                  ready_to_fetcher,
    output logic [31:0]           inst_to_fetcher,
    output logic                  valid_to_mem,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic [127:0]          data_from_mem,
    input  logic                  ready_from_mem
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 4;
    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [127:0]            data_q [LINES];
    logic [ADDR_WIDTH-1:2]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             inst_q, inst_d;
    logic                    ready_q, ready_d;
    logic                    vmem_q, vmem_d;
    logic                    cancel_q, cancel_d;

    logic [INDEX_WIDTH-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]        req_tag, fill_tag;
    logic [127:0]            req_line;
    logic                    hit, accept, fill;
    logic                    unused_pc_bits;

    // Byte-offset bits below the word select carry no information for an instruction cache.
    assign unused_pc_bits = ^pc_from_fetcher[1:0];

    assign req_idx  = pc_from_fetcher[INDEX_WIDTH+3:4];
    assign req_tag  = pc_from_fetcher[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign fill_idx = pc_q[INDEX_WIDTH+3:4];
    assign fill_tag = pc_q[ADDR_WIDTH-1:INDEX_WIDTH+4];
    assign req_line = data_q[req_idx];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept   = rdy && state_q == IDLE && valid_from_fetcher && !ready_q && !flush;
    assign fill     = rdy && state_q == MISS && ready_from_mem;

    // Next-state: lookup in IDLE, wait for the line in MISS; everything holds while rdy is low.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        ready_d  = rdy ? 1'b0 : ready_q;
        vmem_d   = vmem_q;
        cancel_d = cancel_q;
        if (accept) begin
            pc_d = pc_from_fetcher[ADDR_WIDTH-1:2];
            if (hit) begin
                ready_d = 1'b1;
                inst_d  = req_line[{pc_from_fetcher[3:2], 5'b0} +: 32];
            end else begin
                vmem_d  = 1'b1;
                addr_d  = {req_tag, req_idx, 4'b0};
                state_d = MISS;
            end
        end
        if (rdy && state_q == MISS && flush) cancel_d = 1'b1;
        if (fill) begin
            valid_d[fill_idx] = 1'b1;
            vmem_d   = 1'b0;
            state_d  = IDLE;
            cancel_d = 1'b0;
            if (!(cancel_q || flush)) begin
                ready_d = 1'b1;
                inst_d  = data_from_mem[{pc_q[3:2], 5'b0} +: 32];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            pc_q     <= '0;
            addr_q   <= '0;
            inst_q   <= '0;
            ready_q  <= 1'b0;
            vmem_q   <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            ready_q  <= ready_d;
            vmem_q   <= vmem_d;
            cancel_q <= cancel_d;
        end
    end

    // Line storage; contents need no reset because the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= data_from_mem;
        end
    end

    assign ready_to_fetcher = ready_q;
    assign inst_to_fetcher  = inst_q;
    assign valid_to_mem     = vmem_q;
    assign addr_to_mem      = addr_q;
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller's icache port.
- Serves 32-bit instruction words to the fetcher.
- On a miss, issues a 16-byte line request to the memory controller, holds it until the controller's ready pulse, then fills the line and returns the requested word.
- One outstanding miss at a time. No prefetch.

Parameters:
- INDEX_WIDTH, 6, log2 of number of lines (default 64 lines of 16 bytes = 1 KiB).
- ADDR_WIDTH, 32, byte-address width. Tag width = ADDR_WIDTH - INDEX_WIDTH - 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, on clk
- rdy  in  1  global enable; when low, all state and outputs hold
- valid_from_fetcher  in  1  fetch request present
- pc_from_fetcher  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- flush  in  1  one-cycle pulse; abandon the pending fetch (redirect)
- ready_to_fetcher  out  1  one-cycle pulse; inst_to_fetcher is valid
- inst_to_fetcher  out  32  instruction word
- valid_to_mem  out  1  line request to memory controller
- addr_to_mem  out  ADDR_WIDTH  line address; bits [3:0] always 0
- data_from_mem  in  128  filled line; byte k at bits [8k+7:8k]
- ready_from_mem  in  1  one-cycle pulse; data_from_mem valid this cycle

Behaviour:
- Reset:
  - All line valid bits cleared; state IDLE; cancel flag 0.
  - ready_to_fetcher=0, valid_to_mem=0, addr_to_mem=0, inst_to_fetcher=0.
  - Reset mid-miss drops valid_to_mem at once. The memory controller shares rst.
- rdy=0: nothing changes, including ready/valid pulses, which stretch until rdy returns.
- Address split:
  - offset = pc[3:0]
  - index = pc[INDEX_WIDTH+3:4]
  - tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+4]
  - word select = pc[3:2]; word w = line bits [32w+31:32w] (little-endian).
- Request acceptance:
  - Accepted only in IDLE, with valid_from_fetcher=1, ready_to_fetcher=0 and flush=0.
  - pc is latched on acceptance.
  - The fetcher holds pc/valid until ready_to_fetcher, or until it asserts flush.
- State IDLE:
  - Hit (line valid and tag match): next cycle ready_to_fetcher=1 with the word. Stay IDLE. Hit latency is 1 cycle.
  - Miss: next cycle valid_to_mem=1, addr_to_mem={tag,index,4'b0}; go MISS.
- State MISS:
  - valid_to_mem and addr_to_mem are held constant until ready_from_mem.
  - On ready_from_mem:
    - Write data_from_mem, the tag and valid=1 into the line.
    - valid_to_mem<=0; go IDLE.
    - If the cancel flag is 0: ready_to_fetcher<=1 and inst_to_fetcher<=word taken directly from data_from_mem (bypass, not re-read).
    - Clear the cancel flag.
  - Miss latency from acceptance = 1 + controller latency + 1 cycles.
  - valid_to_mem deasserts the cycle after ready_from_mem. The controller suppresses re-acceptance during that cycle, so no duplicate request occurs.
- flush:
  - In IDLE: suppresses acceptance that cycle and forces ready_to_fetcher=0 next cycle, cancelling any hit response.
  - In MISS: sets the cancel flag. The fill still completes and the line is installed, but no response is given.
  - flush in the same cycle as ready_from_mem: line installed, no response.
- ready_to_fetcher is always a single-cycle pulse.
- The cache is never written by stores; self-modifying code is unsupported.
- Conflict misses replace the line unconditionally; no write-back is needed.

Test Plan:
- Cold miss:
  - After reset, fetch pc=0x00000004.
  - Expect valid_to_mem=1, addr_to_mem=0x00000000 one cycle later.
  - Return data_from_mem=0x33221100_77665544_BBAA9988_FFEEDDCC with ready_from_mem.
  - Next cycle: ready_to_fetcher=1, inst=0xBBAA9988, valid_to_mem=0.
- Hit:
  - Then fetch pc=0x0000000C.
  - Expect ready_to_fetcher=1 one cycle later, inst=0x33221100, valid_to_mem stays 0.
- Conflict:
  - Fetch pc=0x00000400 (same index 0, tag 1): miss, addr_to_mem=0x00000400, fill.
  - Then pc=0x00000000 misses again: valid_to_mem re-asserted.
- Flush during miss:
  - Fetch pc=0x00000010 (miss), pulse flush while in MISS, then return ready_from_mem.
  - Expect no ready_to_fetcher pulse.
  - A subsequent fetch of 0x00000010 hits in 1 cycle.
- rdy stall:
  - Drop rdy for 3 cycles while ready_to_fetcher=1.
  - The pulse holds for the 3 cycles, then clears one cycle after rdy returns.
- Reset mid-miss:
  - Assert rst while valid_to_mem=1.
  - Next cycle all outputs are 0; the previously filled pc=0x00000004 now misses.
